// File: rtl/conv_bn_relu_stream_if.sv
// Stream bus of the post-conv batch-norm + ReLU stage: serial parameter load,
// input pixel stream and result stream.
interface conv_bn_relu_stream_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  valid_param_in;
    logic [DATA_WIDTH-1:0] param_in;
    logic                  params_loaded;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] pxl_in;
    logic [DATA_WIDTH-1:0] pxl_out;
    logic                  valid_out;
    logic                  frame_done;
    logic                  err_early;

    modport master (
        output valid_param_in, param_in, valid_in, pxl_in,
        input  params_loaded, pxl_out, valid_out, frame_done, err_early
    );

    modport slave (
        input  valid_param_in, param_in, valid_in, pxl_in,
        output params_loaded, pxl_out, valid_out, frame_done, err_early
    );
endinterface

// File: rtl/conv_bn_relu_stream.sv
// Folded batch-norm + ReLU on a channel-major conv result stream:
// y = ReLU(sat(x*scale[c] + bias[c])), fixed 3-cycle latency, no backpressure.
module conv_bn_relu_stream #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FRAC_BITS    = 8,
    parameter int unsigned IMAGE_WIDTH  = 32,
    parameter int unsigned IMAGE_HEIGHT = 32,
    parameter int unsigned CHANNEL_NUM  = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_bn_relu_stream_if.slave   bus
);
    localparam int unsigned IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned PIX_W      = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned CH_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int unsigned PROD_W     = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W      = PROD_W + 1;

    localparam logic signed [PROD_W-1:0] ROUND   = PROD_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [SUM_W-1:0]  SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}},
                                                    {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]    POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_SCALE,
        S_LOAD_BIAS,
        S_DONE
    } load_state_e;

    load_state_e           state_q;
    logic [CH_W-1:0]       wr_ch_q;
    logic                  params_loaded_q;

    logic signed [DATA_WIDTH-1:0] scale_ram [CHANNEL_NUM];
    logic signed [DATA_WIDTH-1:0] bias_ram  [CHANNEL_NUM];
    logic                         scale_we_c;
    logic                         bias_we_c;

    logic [PIX_W-1:0]             pix_cnt_q;
    logic [CH_W-1:0]              ch_cnt_q;
    logic                         err_early_q;
    logic                         accept_c;
    logic                         last_pix_c;
    logic                         last_ch_c;

    logic                         v1_q, v2_q;
    logic                         last1_q, last2_q;
    logic signed [DATA_WIDTH-1:0] pxl_s1_q;
    logic signed [DATA_WIDTH-1:0] scale_s1_q;
    logic signed [DATA_WIDTH-1:0] bias_s1_q;
    logic signed [DATA_WIDTH-1:0] bias_s2_q;
    logic signed [PROD_W-1:0]     prod_q;

    logic signed [PROD_W-1:0]     rounded_c;
    logic signed [SUM_W-1:0]      sum_c;
    logic [DATA_WIDTH-1:0]        res_c;

    logic [DATA_WIDTH-1:0]        pxl_out_q;
    logic                         valid_out_q;
    logic                         frame_done_q;

    // Parameter load sequencer: scale/bias alternate, channel advances after each bias.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wr_ch_q         <= '0;
            params_loaded_q <= 1'b0;
        end else if (bus.valid_param_in) begin
            unique case (state_q)
                S_IDLE, S_LOAD_SCALE: state_q <= S_LOAD_BIAS;
                S_LOAD_BIAS: begin
                    if (wr_ch_q == CH_W'(CHANNEL_NUM - 1)) begin
                        state_q         <= S_DONE;
                        params_loaded_q <= 1'b1;
                    end else begin
                        wr_ch_q <= wr_ch_q + CH_W'(1);
                        state_q <= S_LOAD_SCALE;
                    end
                end
                default: state_q <= S_DONE;
            endcase
        end
    end

    assign scale_we_c = bus.valid_param_in && !reset &&
                        ((state_q == S_IDLE) || (state_q == S_LOAD_SCALE));
    assign bias_we_c  = bus.valid_param_in && !reset && (state_q == S_LOAD_BIAS);

    // Parameter RAMs keep their contents across reset; read port is stage S1.
    always_ff @(posedge clk) begin
        if (scale_we_c) scale_ram[wr_ch_q] <= bus.param_in;
        if (bias_we_c)  bias_ram[wr_ch_q]  <= bus.param_in;
        scale_s1_q <= scale_ram[ch_cnt_q];
        bias_s1_q  <= bias_ram[ch_cnt_q];
    end

    assign accept_c   = bus.valid_in && params_loaded_q;
    assign last_pix_c = (pix_cnt_q == PIX_W'(IMAGE_SIZE - 1));
    assign last_ch_c  = (ch_cnt_q == CH_W'(CHANNEL_NUM - 1));

    // S3 arithmetic: round, rescale, add bias, saturate, clamp negatives.
    always_comb begin
        rounded_c = (prod_q + ROUND) >>> FRAC_BITS;
        sum_c     = {{(SUM_W-PROD_W){rounded_c[PROD_W-1]}}, rounded_c}
                  + {{(SUM_W-DATA_WIDTH){bias_s2_q[DATA_WIDTH-1]}}, bias_s2_q};
        res_c     = DATA_WIDTH'(sum_c);
        if (sum_c[SUM_W-1]) begin
            res_c = '0;
        end else if (sum_c > SAT_MAX) begin
            res_c = POS_MAX;
        end
    end

    // Counters and pipeline; the counter value at accept time selects the params.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            err_early_q  <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            last1_q      <= 1'b0;
            last2_q      <= 1'b0;
            pxl_s1_q     <= '0;
            prod_q       <= '0;
            bias_s2_q    <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (bus.valid_in && !params_loaded_q) begin
                err_early_q <= 1'b1;
            end
            if (accept_c) begin
                if (last_pix_c) begin
                    pix_cnt_q <= '0;
                    ch_cnt_q  <= last_ch_c ? '0 : ch_cnt_q + CH_W'(1);
                end else begin
                    pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                end
            end

            v1_q     <= accept_c;
            last1_q  <= accept_c && last_pix_c && last_ch_c;
            pxl_s1_q <= bus.pxl_in;

            v2_q      <= v1_q;
            last2_q   <= last1_q;
            prod_q    <= PROD_W'(pxl_s1_q) * PROD_W'(scale_s1_q);
            bias_s2_q <= bias_s1_q;

            valid_out_q  <= v2_q;
            frame_done_q <= last2_q;
            if (v2_q) begin
                pxl_out_q <= res_c;
            end
        end
    end

    assign bus.params_loaded = params_loaded_q;
    assign bus.pxl_out       = pxl_out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.err_early     = err_early_q;
endmodule

// File: tb/tb_conv_bn_relu_stream.sv
// Scoreboard bench for conv_bn_relu_stream: random and directed pixel streams
// checked against an arithmetic batch-norm/ReLU model with exact latency.
module tb_conv_bn_relu_stream;
    localparam int unsigned DW   = 16;
    localparam int unsigned FB   = 8;
    localparam int unsigned IW   = 4;
    localparam int unsigned IH   = 2;
    localparam int unsigned NCH  = 3;
    localparam int unsigned ISZ  = IW * IH;
    localparam int unsigned FRM  = ISZ * NCH;

    typedef struct {
        logic [DW-1:0] px;
        bit            fd;
        int            c;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;

    conv_bn_relu_stream_if #(.DATA_WIDTH(DW)) bus ();

    conv_bn_relu_stream #(
        .DATA_WIDTH  (DW),
        .FRAC_BITS   (FB),
        .IMAGE_WIDTH (IW),
        .IMAGE_HEIGHT(IH),
        .CHANNEL_NUM (NCH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t          sb [$];
    exp_t          mon_e;
    int            n_vec;
    int            n_err;

    logic [DW-1:0] m_scale [NCH];
    logic [DW-1:0] m_bias  [NCH];
    logic [DW-1:0] ps [NCH];
    logic [DW-1:0] pb [NCH];
    bit            m_loaded;
    bit            m_early;
    int            m_wptr;
    int            m_idx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_bn(input logic [DW-1:0] x, input logic [DW-1:0] s,
                                             input logic [DW-1:0] b);
        longint p;
        longint maxv;
        maxv = (longint'(1) << (DW - 1)) - 1;
        p = longint'($signed(x)) * longint'($signed(s));
        p = (p + (longint'(1) << (FB - 1))) >>> FB;
        p = p + longint'($signed(b));
        if (p > maxv) p = maxv;
        if (p < 0) p = 0;
        return DW'(p);
    endfunction

    // One bus cycle; the model sees the same gating the stage is defined to apply.
    task automatic cyc_drive(input bit vp, input logic [DW-1:0] pw,
                             input bit vi, input logic [DW-1:0] px);
        exp_t e;
        int   ch;
        @(posedge clk);
        #1;
        bus.valid_param_in = vp;
        bus.param_in       = pw;
        bus.valid_in       = vi;
        bus.pxl_in         = px;
        if (vi) begin
            if (m_loaded) begin
                ch   = m_idx / ISZ;
                e.px = ref_bn(px, m_scale[ch], m_bias[ch]);
                e.fd = (m_idx == FRM - 1);
                e.c  = cyc + 3;
                sb.push_back(e);
                m_idx = (m_idx + 1) % FRM;
            end else begin
                m_early = 1'b1;
            end
        end
        if (vp && !m_loaded) begin
            if (m_wptr % 2 == 0) m_scale[m_wptr / 2] = pw;
            else                 m_bias[m_wptr / 2]  = pw;
            m_wptr++;
            if (m_wptr == 2 * NCH) m_loaded = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, DW'($urandom), 1'b0, DW'($urandom));
    endtask

    task automatic pix(input logic [DW-1:0] px);
        cyc_drive(1'b0, DW'($urandom), 1'b1, px);
    endtask

    task automatic rand_stream(input int n, input int pct, input bit pnoise);
        for (int i = 0; i < n; i++) begin
            cyc_drive(pnoise && ($urandom_range(3) == 0), DW'($urandom),
                      ($urandom_range(99) < pct), DW'($urandom));
        end
    endtask

    task automatic load_params(input bit noisy);
        for (int i = 0; i < 2 * int'(NCH); i++) begin
            if (noisy) begin
                repeat ($urandom_range(2)) cyc_drive(1'b0, DW'($urandom), 1'($urandom), DW'($urandom));
            end
            cyc_drive(1'b1, (i % 2 == 0) ? ps[i / 2] : pb[i / 2],
                      noisy && ($urandom_range(1) == 1), DW'($urandom));
        end
    endtask

    // Reset is sampled one edge later; anything due after that edge is flushed.
    task automatic do_reset();
        int k;
        @(posedge clk);
        #1;
        k = cyc;
        reset              = 1'b1;
        bus.valid_param_in = 1'b0;
        bus.valid_in       = 1'b0;
        m_loaded = 1'b0;
        m_early  = 1'b0;
        m_wptr   = 0;
        m_idx    = 0;
        @(negedge clk);
        #1;
        while (sb.size() > 0 && sb[$].c > k) void'(sb.pop_back());
        @(negedge clk);
        chk("reset valid_out", longint'(bus.valid_out), 0);
        chk("reset params_loaded", longint'(bus.params_loaded), 0);
        chk("reset frame_done", longint'(bus.frame_done), 0);
        chk("reset err_early", longint'(bus.err_early), 0);
        chk("reset pxl_out", longint'(bus.pxl_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        idle(2);
        chk("scoreboard drained", longint'(sb.size()), 0);
    endtask

    task automatic check_flags();
        @(negedge clk);
        chk("params_loaded", longint'(bus.params_loaded), longint'(m_loaded));
        chk("err_early", longint'(bus.err_early), longint'(m_early));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.valid_param_in = 1'b0;
        bus.param_in       = '0;
        bus.valid_in       = 1'b0;
        bus.pxl_in         = '0;

        fork
            forever begin
                @(negedge clk);
                if (bus.valid_out === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected valid_out", longint'(bus.valid_out), 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("pxl_out", longint'(bus.pxl_out), longint'(mon_e.px));
                        chk("frame_done", longint'(bus.frame_done), longint'(mon_e.fd));
                        chk("latency cycle", longint'(cyc), longint'(mon_e.c));
                    end
                end else if (bus.frame_done === 1'b1) begin
                    chk("frame_done without valid_out", longint'(bus.frame_done), 0);
                end
            end
        join_none

        // Identity params, early pixels, stray param words after load.
        do_reset();
        pix(16'h0100);
        pix(16'h0200);
        idle(4);
        check_flags();
        for (int c = 0; c < int'(NCH); c++) begin
            ps[c] = 16'h0100;
            pb[c] = 16'h0000;
        end
        load_params(1'b1);
        idle(1);
        check_flags();
        pix(16'h0280);
        cyc_drive(1'b1, 16'hDEAD, 1'b1, 16'h0001);
        rand_stream(20, 80, 1'b1);
        drain();

        // Bias/ReLU on ch0, saturation on ch1, rounding on ch2.
        do_reset();
        ps[0] = 16'h0100; pb[0] = 16'hFF00;
        ps[1] = 16'h7FFF; pb[1] = 16'h0000;
        ps[2] = 16'h0080; pb[2] = 16'h0000;
        load_params(1'b0);
        idle(1);
        check_flags();
        pix(16'h0080);
        pix(16'h0300);
        repeat (ISZ - 2) pix(DW'($urandom));
        pix(16'h7FFF);
        repeat (ISZ - 1) pix(DW'($urandom));
        pix(16'h0001);
        repeat (ISZ - 1) pix(DW'($urandom));
        rand_stream(30, 60, 1'b0);
        drain();

        // Exact channel switch, back-to-back, then reset at pixel 5 of ch1.
        do_reset();
        ps[0] = 16'h0100; pb[0] = 16'h0000;
        ps[1] = 16'h0200; pb[1] = 16'h0000;
        ps[2] = 16'h0100; pb[2] = 16'h0040;
        load_params(1'b0);
        idle(1);
        repeat (ISZ + 1) pix(16'h0100);
        repeat (FRM - ISZ - 1) pix(DW'($urandom));
        repeat (ISZ + 5) pix(DW'($urandom));
        do_reset();
        idle(3);
        check_flags();

        // Reload random params and stream multiple frames with gaps.
        for (int c = 0; c < int'(NCH); c++) begin
            ps[c] = DW'($urandom);
            pb[c] = DW'($urandom);
        end
        load_params(1'b1);
        pix(16'h0100);
        rand_stream(80, 70, 1'b1);
        drain();
        check_flags();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
